// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : sram_axi_bridge
//  Purpose  : Bridges the core's SRAM-like instruction-fetch and data
//             load/store channels onto a single AXI3 master port. Only one
//             transaction is in flight at a time, and data requests win
//             arbitration over instruction requests. Because the bridge
//             serialises everything, a read that follows a write always
//             observes that write.
//  Ports    : clk, resetn                     - clock, async active-low reset
//             inst_*                          - instruction SRAM-like channel
//             data_*                          - data SRAM-like channel
//             ar*/r*                          - AXI read address / data
//             aw*/w*/b*                       - AXI write address / data / resp
//             Constant AXI fields (len, burst, lock, cache, prot, awid, wid,
//             wlast) are tied off by the enclosing level.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_axi_bridge (
    input  logic        clk,
    input  logic        resetn,
    // instruction channel
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data channel
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_RESP = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Latched request payload
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_is_data;     // 1 = request came from the data channel

    // Per-channel completion flags while in S_WR_REQ
    logic        r_aw_done;
    logic        r_w_done;

    logic        r_inst_data_ok;
    logic        r_data_data_ok;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;

    logic        w_data_acc;
    logic        w_inst_acc;
    logic        w_ar_fire;
    logic        w_r_fire;
    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_b_fire;
    logic        w_aw_done;
    logic        w_w_done;
    logic        w_unused;

    // The response ID is never checked; only one transaction is outstanding.
    assign w_unused = ^rid;

    // ------------------------------------------------------------------------
    // Arbitration: data channel has priority; nothing accepted unless idle.
    // ------------------------------------------------------------------------
    assign w_data_acc   = (r_state == S_IDLE) & data_req;
    assign w_inst_acc   = (r_state == S_IDLE) & inst_req & ~data_req;
    assign data_addr_ok = w_data_acc;
    assign inst_addr_ok = w_inst_acc;

    assign w_ar_fire = arvalid & arready;
    assign w_r_fire  = rvalid  & rready;
    assign w_aw_fire = awvalid & awready;
    assign w_w_fire  = wvalid  & wready;
    assign w_b_fire  = bvalid  & bready;

    // "Done" includes a handshake happening this very cycle so that AW and W
    // completing together (or in either order) all reach S_WR_RESP.
    assign w_aw_done = r_aw_done | w_aw_fire;
    assign w_w_done  = r_w_done  | w_w_fire;

    // Payloads are driven straight from the latched request registers.
    assign arid   = {3'b000, r_is_data};
    assign araddr = r_addr;
    assign arsize = {1'b0, r_size};
    assign awaddr = r_addr;
    assign awsize = {1'b0, r_size};
    assign wdata  = r_wdata;
    assign wstrb  = r_wstrb;

    assign inst_data_ok = r_inst_data_ok;
    assign data_data_ok = r_data_data_ok;
    assign inst_rdata   = r_inst_rdata;
    assign data_rdata   = r_data_rdata;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and AXI valid/ready generation
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_data_acc) begin
                    w_next_state = data_wr ? S_WR_REQ : S_RD_REQ;
                end else if (w_inst_acc) begin
                    w_next_state = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                arvalid = 1'b1;
                if (w_ar_fire) begin
                    w_next_state = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                rready = 1'b1;
                if (w_r_fire) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WR_REQ: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                if (w_aw_done & w_w_done) begin
                    w_next_state = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (w_b_fire) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch, write-channel progress and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr         <= 32'h0;
            r_size         <= 2'b00;
            r_wstrb        <= 4'h0;
            r_wdata        <= 32'h0;
            r_is_data      <= 1'b0;
            r_aw_done      <= 1'b0;
            r_w_done       <= 1'b0;
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
            r_inst_rdata   <= 32'h0;
            r_data_rdata   <= 32'h0;
        end else begin
            if (w_data_acc) begin
                r_addr    <= data_addr;
                r_size    <= data_size;
                r_wstrb   <= data_wstrb;
                r_wdata   <= data_wdata;
                r_is_data <= 1'b1;
            end else if (w_inst_acc) begin
                r_addr    <= inst_addr;
                r_size    <= inst_size;
                r_wstrb   <= 4'h0;
                r_wdata   <= 32'h0;
                r_is_data <= 1'b0;
            end

            // Flags are cleared on leaving S_WR_REQ so the next store starts fresh.
            if (r_state == S_WR_REQ) begin
                if (w_aw_done & w_w_done) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    r_aw_done <= w_aw_done;
                    r_w_done  <= w_w_done;
                end
            end

            // data_ok strobes are one cycle wide by construction: the FSM
            // leaves the response state on the same edge.
            r_inst_data_ok <= w_r_fire & ~r_is_data;
            r_data_data_ok <= (w_r_fire & r_is_data) | w_b_fire;

            if (w_r_fire & ~r_is_data) begin
                r_inst_rdata <= rdata;
            end
            if (w_r_fire & r_is_data) begin
                r_data_rdata <= rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_axi_bridge
//  Purpose  : Directed self-checking bench for sram_axi_bridge. The bench
//             plays the role of both SRAM-like requesters and the AXI slave,
//             driving handshakes by hand cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int          vec_cnt;
    int          err_cnt;
    logic [31:0] mem_word;

    sram_axi_bridge dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .arid         (arid),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready),
        .awaddr       (awaddr),
        .awsize       (awsize),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 2 ns after the next rising edge; inputs are driven there and
    // outputs sampled 1 ns later, well clear of either clock edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".arvalid"}, {31'h0, arvalid}, 32'h0);
        chk({tag, ".rready"},  {31'h0, rready},  32'h0);
        chk({tag, ".awvalid"}, {31'h0, awvalid}, 32'h0);
        chk({tag, ".wvalid"},  {31'h0, wvalid},  32'h0);
        chk({tag, ".bready"},  {31'h0, bready},  32'h0);
        chk({tag, ".i_dok"},   {31'h0, inst_data_ok}, 32'h0);
        chk({tag, ".d_dok"},   {31'h0, data_data_ok}, 32'h0);
        chk({tag, ".i_rdata"}, inst_rdata, 32'h0);
        chk({tag, ".d_rdata"}, data_rdata, 32'h0);
        chk({tag, ".araddr"},  araddr, 32'h0);
    endtask

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        mem_word   = 32'h0;
        resetn     = 1'b0;
        inst_req   = 1'b0;
        inst_size  = 2'd2;
        inst_addr  = 32'h0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_wstrb = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        arready    = 1'b0;
        rid        = 4'h0;
        rdata      = 32'h0;
        rvalid     = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;

        // ---------------- reset state ----------------
        cyc(); cyc(); #1;
        chk_all_zero("reset");
        resetn = 1'b1;

        // ---------------- single fetch, minimum latency ----------------
        cyc();                                        // T0
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; inst_size = 2'd2; arready = 1'b1;
        #1;
        chk("f.iaok_T0", {31'h0, inst_addr_ok}, 32'h1);
        chk("f.daok_T0", {31'h0, data_addr_ok}, 32'h0);
        cyc();                                        // T1
        inst_req = 1'b0;
        #1;
        chk("f.arvalid", {31'h0, arvalid}, 32'h1);
        chk("f.arid",    {28'h0, arid},    32'h0);
        chk("f.arsize",  {29'h0, arsize},  32'h2);
        chk("f.araddr",  araddr,           32'h1C00_0000);
        cyc();                                        // T2
        rvalid = 1'b1; rdata = 32'h0280_0C0C; rid = 4'h0;
        #1;
        chk("f.rready",  {31'h0, rready},  32'h1);
        chk("f.dok_T2",  {31'h0, inst_data_ok}, 32'h0);
        cyc();                                        // T3
        rvalid = 1'b0;
        #1;
        chk("f.dok_T3",  {31'h0, inst_data_ok}, 32'h1);
        chk("f.irdata",  inst_rdata, 32'h0280_0C0C);
        chk("f.ddok_T3", {31'h0, data_data_ok}, 32'h0);
        chk("f.rready0", {31'h0, rready}, 32'h0);
        cyc();                                        // T4
        #1;
        chk("f.dok_T4",  {31'h0, inst_data_ok}, 32'h0);
        chk("f.ihold",   inst_rdata, 32'h0280_0C0C);

        // ---------------- arbitration: data beats inst ----------------
        cyc();                                        // T0
        inst_req = 1'b1; inst_addr = 32'h1C00_0004;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1004;
        #1;
        chk("arb.daok",  {31'h0, data_addr_ok}, 32'h1);
        chk("arb.iaok",  {31'h0, inst_addr_ok}, 32'h0);
        cyc();                                        // T1
        data_req = 1'b0;
        #1;
        chk("arb.iaok_busy", {31'h0, inst_addr_ok}, 32'h0);
        chk("arb.arid",      {28'h0, arid}, 32'h1);
        chk("arb.araddr",    araddr, 32'h0000_1004);
        cyc();                                        // T2
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rid = 4'h1;
        #1;
        chk("arb.iaok_resp", {31'h0, inst_addr_ok}, 32'h0);
        cyc();                                        // T3
        rvalid = 1'b0;
        #1;
        chk("arb.ddok",      {31'h0, data_data_ok}, 32'h1);
        chk("arb.drdata",    data_rdata, 32'hDEAD_BEEF);
        chk("arb.idok",      {31'h0, inst_data_ok}, 32'h0);
        chk("arb.iaok_dok",  {31'h0, inst_addr_ok}, 32'h1);
        cyc();                                        // T4
        inst_req = 1'b0;
        #1;
        chk("arb.ddok_T4",   {31'h0, data_data_ok}, 32'h0);
        chk("arb.arid_i",    {28'h0, arid}, 32'h0);
        chk("arb.araddr_i",  araddr, 32'h1C00_0004);
        cyc();                                        // T5
        rvalid = 1'b1; rdata = 32'h1111_1111; rid = 4'h0;
        #1;
        cyc();                                        // T6
        rvalid = 1'b0; arready = 1'b0;
        #1;
        chk("arb.idok2",     {31'h0, inst_data_ok}, 32'h1);
        chk("arb.irdata2",   inst_rdata, 32'h1111_1111);
        chk("arb.dhold",     data_rdata, 32'hDEAD_BEEF);

        // ---------------- store byte, split AW/W handshakes ----------------
        cyc();                                        // T0
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h0000_0003;
        data_wstrb = 4'b1000; data_wdata = 32'hAB00_0000;
        #1;
        chk("st.daok",   {31'h0, data_addr_ok}, 32'h1);
        cyc();                                        // T1
        data_req = 1'b0; data_wr = 1'b0; awready = 1'b1;
        #1;
        chk("st.awvalid1", {31'h0, awvalid}, 32'h1);
        chk("st.wvalid1",  {31'h0, wvalid},  32'h1);
        chk("st.awaddr",   awaddr, 32'h0000_0003);
        chk("st.awsize",   {29'h0, awsize}, 32'h0);
        chk("st.wstrb",    {28'h0, wstrb}, 32'h8);
        chk("st.wdata",    wdata, 32'hAB00_0000);
        chk("st.arvalid",  {31'h0, arvalid}, 32'h0);
        cyc();                                        // T2
        awready = 1'b0;
        #1;
        chk("st.awvalid2", {31'h0, awvalid}, 32'h0);
        chk("st.wvalid2",  {31'h0, wvalid},  32'h1);
        cyc();                                        // T3
        #1;
        chk("st.wvalid3",  {31'h0, wvalid},  32'h1);
        chk("st.bready3",  {31'h0, bready},  32'h0);
        cyc();                                        // T4
        wready = 1'b1;
        #1;
        chk("st.wvalid4",  {31'h0, wvalid},  32'h1);
        chk("st.awvalid4", {31'h0, awvalid}, 32'h0);
        cyc();                                        // T5
        wready = 1'b0;
        #1;
        chk("st.wvalid5",  {31'h0, wvalid},  32'h0);
        chk("st.bready5",  {31'h0, bready},  32'h1);
        cyc();                                        // T6
        bvalid = 1'b1;
        #1;
        chk("st.ddok6",    {31'h0, data_data_ok}, 32'h0);
        cyc();                                        // T7
        bvalid = 1'b0;
        #1;
        chk("st.ddok7",    {31'h0, data_data_ok}, 32'h1);
        chk("st.bready7",  {31'h0, bready}, 32'h0);
        cyc();                                        // T8
        #1;
        chk("st.ddok8",    {31'h0, data_data_ok}, 32'h0);

        // ---------------- stray rvalid in IDLE is ignored ----------------
        rvalid = 1'b1; rdata = 32'h5555_5555;
        #1;
        chk("stray.rready", {31'h0, rready}, 32'h0);
        cyc();
        rvalid = 1'b0;
        #1;
        chk("stray.idok",   {31'h0, inst_data_ok}, 32'h0);
        chk("stray.ihold",  inst_rdata, 32'h1111_1111);

        // ---------------- AR back-pressure ----------------
        cyc();                                        // T0
        inst_req = 1'b1; inst_addr = 32'h1C00_0008; arready = 1'b0;
        #1;
        chk("bp.iaok",   {31'h0, inst_addr_ok}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000;
            #1;
            chk("bp.arvalid", {31'h0, arvalid}, 32'h1);
            chk("bp.araddr",  araddr, 32'h1C00_0008);
            chk("bp.iaok0",   {31'h0, inst_addr_ok}, 32'h0);
            chk("bp.daok0",   {31'h0, data_addr_ok}, 32'h0);
        end
        cyc();
        inst_req = 1'b0; data_req = 1'b0; arready = 1'b1;
        #1;
        chk("bp.arvalid_f", {31'h0, arvalid}, 32'h1);
        cyc();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h2222_2222;
        #1;
        cyc();
        rvalid = 1'b0;
        #1;
        chk("bp.idok",   {31'h0, inst_data_ok}, 32'h1);
        chk("bp.irdata", inst_rdata, 32'h2222_2222);

        // ---------------- reset during RD_RESP ----------------
        cyc();
        inst_req = 1'b1; inst_addr = 32'h1C00_000C; arready = 1'b1;
        #1;
        cyc();
        inst_req = 1'b0;
        #1;
        cyc();
        arready = 1'b0;
        #1;
        chk("rst.rready_pre", {31'h0, rready}, 32'h1);
        resetn = 1'b0;
        #1;
        chk_all_zero("rst");
        cyc();
        resetn = 1'b1;
        #1;
        cyc();                                        // fresh fetch T0
        inst_req = 1'b1; inst_addr = 32'h1C00_0010; arready = 1'b1;
        #1;
        chk("rst2.iaok", {31'h0, inst_addr_ok}, 32'h1);
        cyc();
        inst_req = 1'b0;
        #1;
        chk("rst2.araddr", araddr, 32'h1C00_0010);
        cyc();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h3333_3333;
        #1;
        cyc();
        rvalid = 1'b0;
        #1;
        chk("rst2.idok",   {31'h0, inst_data_ok}, 32'h1);
        chk("rst2.irdata", inst_rdata, 32'h3333_3333);

        // ---------------- store then load to the same address ----------------
        cyc();                                        // T0
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_0010;
        data_wstrb = 4'hF; data_wdata = 32'h1234_5678; awready = 1'b1; wready = 1'b1;
        #1;
        chk("rw.daok_st", {31'h0, data_addr_ok}, 32'h1);
        cyc();                                        // T1: load already requested
        data_wr = 1'b0; data_wdata = 32'h0;
        #1;
        chk("rw.awvalid", {31'h0, awvalid}, 32'h1);
        chk("rw.wvalid",  {31'h0, wvalid},  32'h1);
        chk("rw.daok_busy", {31'h0, data_addr_ok}, 32'h0);
        mem_word = wdata;
        cyc();                                        // T2
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #1;
        chk("rw.arvalid_wr", {31'h0, arvalid}, 32'h0);
        chk("rw.bready",     {31'h0, bready}, 32'h1);
        cyc();                                        // T3
        bvalid = 1'b0;
        #1;
        chk("rw.ddok_st",    {31'h0, data_data_ok}, 32'h1);
        chk("rw.daok_ld",    {31'h0, data_addr_ok}, 32'h1);
        chk("rw.arvalid_b",  {31'h0, arvalid}, 32'h0);
        cyc();                                        // T4
        data_req = 1'b0; arready = 1'b1;
        #1;
        chk("rw.arvalid_ld", {31'h0, arvalid}, 32'h1);
        chk("rw.araddr_ld",  araddr, 32'h0000_0010);
        chk("rw.arid_ld",    {28'h0, arid}, 32'h1);
        cyc();
        arready = 1'b0; rvalid = 1'b1; rdata = mem_word; rid = 4'h1;
        #1;
        cyc();
        rvalid = 1'b0;
        #1;
        chk("rw.ddok_ld",  {31'h0, data_data_ok}, 32'h1);
        chk("rw.drdata",   data_rdata, 32'h1234_5678);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Converts the core's two SRAM-like channels (instruction fetch, data load/store) into one AXI3 master port.
- Sits directly downstream of the CPU core, between the core's memory interfaces and the external AXI interconnect or RAM model.
- Allows one transaction in flight. Data requests have priority over instruction requests.
- Read-after-write ordering is therefore guaranteed by construction.

Parameters:
- None. Address and data widths are fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- resetn  input  1  reset; asynchronous, active-low
- inst_req  input  1  instruction read request (read-only channel)
- inst_size  input  2  bytes = 2^size; instruction fetch always uses 2
- inst_addr  input  32  fetch byte address
- inst_addr_ok  output  1  instruction request accepted this cycle
- inst_data_ok  output  1  one-cycle pulse; inst_rdata valid
- inst_rdata  output  32  fetched word
- data_req  input  1  data request
- data_wr  input  1  1 = store, 0 = load
- data_size  input  2  0 = byte, 1 = half, 2 = word
- data_wstrb  input  4  byte enables for stores
- data_addr  input  32  data byte address
- data_wdata  input  32  store data
- data_addr_ok  output  1  data request accepted this cycle
- data_data_ok  output  1  one-cycle pulse; load data returned or store completed
- data_rdata  output  32  load word
- arid/araddr/arsize  output  4/32/3  AR payload
- arvalid  output  1  AR valid
- arready  input  1  AR ready
- rid/rdata  input  4/32  R payload (rresp and rlast are ignored)
- rvalid  input  1  R valid
- rready  output  1  R ready
- awaddr/awsize  output  32/3  AW payload
- awvalid  output  1  AW valid
- awready  input  1  AW ready
- wdata/wstrb  output  32/4  W payload
- wvalid  output  1  W valid
- wready  input  1  W ready
- bvalid  input  1  B valid
- bready  output  1  B ready
- Constant AXI fields are tied at top level, not in this block:
  - len = 0, burst = INCR, lock/cache/prot = 0
  - awid = 1, wid = 1, wlast = 1

Behaviour:
- Reset values (asynchronous on resetn = 0), all forced to 0:
  - state = IDLE; all AXI valid/ready outputs
  - inst_data_ok, data_data_ok, inst_rdata, data_rdata
  - all latched payload registers
- States: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP.
- IDLE arbitration and handshake:
  - data_addr_ok = (state == IDLE) & data_req.
  - inst_addr_ok = (state == IDLE) & inst_req & ~data_req.
  - addr_ok is combinational.
  - On an addr_ok handshake the bridge latches the request (addr, size, wstrb, wdata, source) into registers.
- State transitions:
  - IDLE → RD_REQ on an accepted load or fetch.
  - IDLE → WR_REQ on an accepted store.
- RD_REQ:
  - arvalid = 1 with the latched payload.
  - arid = 0 for inst, 1 for data; arsize = {1'b0, size}; araddr = latched address unmodified.
  - arvalid and its payload stay stable until arready.
  - On arvalid & arready → RD_RESP.
- RD_RESP:
  - rready = 1.
  - On rvalid & rready: register rdata into the source's *_rdata and assert that source's *_data_ok for exactly the next cycle; → IDLE.
- WR_REQ:
  - awvalid and wvalid are raised together.
  - Each valid drops independently once its own handshake completes; per-channel done flags record this.
  - When both AW and W are done → WR_RESP. AW and W completing in the same cycle is legal.
- WR_RESP:
  - bready = 1.
  - On bvalid: pulse data_data_ok the next cycle; → IDLE.
- Latency:
  - Minimum request-to-data_ok = 3 cycles (addr_ok at T, arvalid at T+1, rvalid at T+2, data_ok at T+3).
  - A new request can be accepted in the same cycle data_ok is high, because state is IDLE then.
- *_rdata holds its value until the next read response for that source.
- Unexpected responses are ignored:
  - rid is not checked.
  - rvalid or bvalid outside RD_RESP/WR_RESP is ignored (rready/bready are 0 there).
- Back-pressure: while state ≠ IDLE, both addr_ok outputs are 0; requesters keep req asserted.
- Reset mid-transaction: the asynchronous reset abandons the transfer immediately and all valids drop. The whole system resets together, so this AXI protocol break is acceptable.

Test Plan:
- Fetch 0x1C000000, arready = 1, rvalid one cycle later with rdata = 0x02800C0C → inst_addr_ok at T0, arid = 0, arsize = 2, inst_data_ok at T3 with inst_rdata = 0x02800C0C, one cycle wide.
- inst_req and data_req (load 0x00001004) in the same cycle → data_addr_ok = 1, inst_addr_ok = 0; inst is accepted in the cycle data_data_ok pulses.
- Store byte: data_addr = 0x00000003, wstrb = 4'b1000, wdata = 0xAB000000; awready at T+1, wready delayed to T+4, bvalid at T+6 → awvalid drops after T+1, wvalid held until T+4, data_data_ok at T+7.
- arready low for 5 cycles → arvalid and araddr stable throughout; no addr_ok pulses to either channel.
- resetn asserted in RD_RESP → all outputs 0 immediately; after release, a fresh fetch completes normally.
- Back-to-back: store 0x10 then load 0x10 → load's arvalid only after the store's bvalid; load returns the value written.
